// File: rtl/fp_to_int_if.sv
// Handshake bundle for the float-to-int converter: an input stream of
// IEEE-754 singles and an output stream of integers with exception flags.
interface fp_to_int_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp_to_int.sv
// Multi-cycle IEEE-754 single to int32 converter, round-to-nearest-even.
// Right shifts are spread over ALIGN cycles, STEP bits per cycle.
module fp_to_int #(
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_to_int_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  count_q, count_d;
  logic        sign_q, sign_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [2:0]  out_flags_q, out_flags_d;

  logic        accept;
  logic [7:0]  e;
  logic [22:0] frac;
  logic        sgn;
  logic [23:0] m;
  logic [31:0] mag_t;
  logic        g_t, s_t;
  logic [4:0]  cnt_t;
  logic [31:0] rnd;

  assign bus.in_ready  = rst_n & (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign sgn    = bus.in_data[31];
  assign e      = bus.in_data[30:23];
  assign frac   = bus.in_data[22:0];
  assign m      = {1'b1, frac};

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    count_d     = count_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    mag_t       = mag_q;
    g_t         = guard_q;
    s_t         = sticky_q;
    cnt_t       = count_q;
    rnd         = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d   = sgn;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          count_d  = '0;
          mag_d    = '0;
          if (e == 8'd255) begin
            // NaN always saturates positive; only -inf maps to INT_MIN
            out_data_d  = (sgn && frac == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            out_flags_d = 3'b100;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (e == 8'd0) begin
            out_data_d  = '0;
            out_flags_d = {2'b00, |frac};
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (e <= 8'd125) begin
            out_data_d  = '0;
            out_flags_d = 3'b001;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (e >= 8'd158) begin
            if (bus.in_data == 32'hCF00_0000) begin
              out_data_d  = 32'h8000_0000;
              out_flags_d = 3'b000;
            end else begin
              out_data_d  = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
              out_flags_d = 3'b010;
            end
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (e <= 8'd149) begin
            mag_d   = {8'd0, m};
            count_d = 5'(8'd150 - e);
            state_d = S_ALIGN;
          end else begin
            // integer-valued inputs: exact left shift, nothing to round
            mag_d   = {8'd0, m} << (e - 8'd150);
            state_d = S_ROUND;
          end
        end
      end

      S_ALIGN: begin
        for (int k = 0; k < STEP; k++) begin
          if (cnt_t != 5'd0) begin
            s_t   = s_t | g_t;
            g_t   = mag_t[0];
            mag_t = mag_t >> 1;
            cnt_t = cnt_t - 5'd1;
          end
        end
        mag_d    = mag_t;
        guard_d  = g_t;
        sticky_d = s_t;
        count_d  = cnt_t;
        if (cnt_t == 5'd0) state_d = S_ROUND;
      end

      S_ROUND: begin
        rnd         = mag_q + {31'd0, guard_q & (sticky_q | mag_q[0])};
        out_data_d  = sign_q ? -rnd : rnd;
        out_flags_d = {2'b00, guard_q | sticky_q};
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule
